// File: rtl/uart_hex_decoder.sv
// ASCII hex command parser: accumulates lowercase hex digits from a UART byte
// stream and emits {code, value} words on command characters.
module uart_hex_decoder #(
    parameter logic [7:0] CHAR_WRITE = 8'h57,
    parameter logic [7:0] CHAR_READ  = 8'h52,
    parameter logic [7:0] CHAR_ADDR  = 8'h41,
    parameter logic [7:0] CHAR_RST   = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    input  logic        i_busy,
    output logic        o_stb,
    output logic [33:0] o_word,
    output logic        o_err
);

    typedef enum logic {EMPTY, DIGITS} state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stb_d, err_d;
    logic [33:0] word_d;

    logic        is_digit, is_ignore, is_cmd, needs_digits, xfer;
    logic [3:0]  nibble;
    logic [1:0]  code;

    // Byte classification
    always_comb begin
        is_digit  = 1'b0;
        nibble    = 4'h0;
        if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = i_rx_data[3:0];
        end else if (i_rx_data >= 8'h61 && i_rx_data <= 8'h66) begin
            is_digit = 1'b1;
            nibble   = i_rx_data[3:0] + 4'd9;
        end
        is_ignore = (i_rx_data == 8'h20) || (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);

        is_cmd       = 1'b1;
        code         = 2'b00;
        needs_digits = 1'b0;
        if (i_rx_data == CHAR_WRITE) begin
            code         = 2'b00;
            needs_digits = 1'b1;
        end else if (i_rx_data == CHAR_READ) begin
            code = 2'b01;
        end else if (i_rx_data == CHAR_ADDR) begin
            code         = 2'b10;
            needs_digits = 1'b1;
        end else if (i_rx_data == CHAR_RST) begin
            code = 2'b11;
        end else begin
            is_cmd = 1'b0;
        end
    end

    // A pending word may be replaced only on the cycle it is taken
    assign xfer = o_stb & ~i_busy;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        stb_d   = xfer ? 1'b0 : o_stb;
        word_d  = o_word;
        err_d   = 1'b0;

        if (i_rx_stb) begin
            if (is_digit) begin
                acc_d   = {acc_q[27:0], nibble};
                cnt_d   = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
                state_d = DIGITS;
            end else if (is_cmd) begin
                if (o_stb && !xfer) begin
                    err_d = 1'b1;
                end else if (needs_digits && state_q == EMPTY) begin
                    err_d = 1'b1;
                end else begin
                    word_d  = {code, (code == 2'b11) ? 32'h0 : acc_q};
                    stb_d   = 1'b1;
                    acc_d   = 32'h0;
                    cnt_d   = 4'd0;
                    state_d = EMPTY;
                end
            end else if (!is_ignore) begin
                acc_d   = 32'h0;
                cnt_d   = 4'd0;
                state_d = EMPTY;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= EMPTY;
            acc_q   <= 32'h0;
            cnt_q   <= 4'd0;
            o_stb   <= 1'b0;
            o_word  <= 34'h0;
            o_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_stb   <= stb_d;
            o_word  <= word_d;
            o_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_hex_decoder.sv
// Directed vector bench for uart_hex_decoder: table of byte strings plus
// hand-written busy / reset / back-to-back sequences.
module tb_uart_hex_decoder;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_rx_stb = 1'b0;
    logic [7:0]  i_rx_data = 8'h0;
    logic        i_busy = 1'b0;
    logic        o_stb;
    logic [33:0] o_word;
    logic        o_err;

    uart_hex_decoder dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_rx_stb  (i_rx_stb),
        .i_rx_data (i_rx_data),
        .i_busy    (i_busy),
        .o_stb     (o_stb),
        .o_word    (o_word),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [95:0] chars;
        int          len;
        int          exp_stb;
        logic [33:0] exp_word;
        int          exp_err;
    } vec_t;

    vec_t vecs[10];
    int   n_checks = 0;
    int   n_errors = 0;

    // Transfer / error monitor sampled on the falling edge
    int          n_xfer = 0;
    int          n_errp = 0;
    logic [33:0] last_word = 34'h0;
    always @(negedge i_clk) begin
        if (o_stb && !i_busy) begin
            n_xfer    <= n_xfer + 1;
            last_word <= o_word;
        end
        if (o_err) n_errp <= n_errp + 1;
    end

    function automatic vec_t mk(logic [95:0] c, int len, int stb, logic [33:0] w, int err);
        vec_t v;
        v.chars = c; v.len = len; v.exp_stb = stb; v.exp_word = w; v.exp_err = err;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Byte is sampled on the next rising edge; returns at edge + 1
    task automatic send(logic [7:0] b);
        i_rx_stb  = 1'b1;
        i_rx_data = b;
        tick(1);
        i_rx_stb  = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        tick(2);
        i_reset = 1'b1;
        tick(1);
    endtask

    int base_x, base_e;

    initial begin
        vecs[0] = mk("1234abcdW", 9, 1, 34'h0_1234_abcd, 0);
        vecs[1] = mk("R", 1, 1, 34'h1_0000_0000, 0);
        vecs[2] = mk("123456789A", 10, 1, 34'h2_2345_6789, 0);
        vecs[3] = mk("W", 1, 0, 34'h0, 1);
        vecs[4] = mk("12xR", 4, 1, 34'h1_0000_0000, 1);
        vecs[5] = mk("ffZ", 3, 1, 34'h3_0000_0000, 0);
        vecs[6] = mk({"9", " ", 8'h0d, 8'h0a, "A"}, 5, 1, 34'h2_0000_0009, 0);
        vecs[7] = mk("A1W", 3, 1, 34'h0_0000_0001, 1);
        vecs[8] = mk("Fa0R", 4, 1, 34'h1_0000_00a0, 1);
        vecs[9] = mk("deadbeefW", 9, 1, 34'h0_dead_beef, 0);

        // Reset state
        tick(2);
        check("reset_stb", 64'(o_stb), 64'h0);
        check("reset_word", 64'(o_word), 64'h0);
        check("reset_err", 64'(o_err), 64'h0);
        i_reset = 1'b1;
        tick(1);

        foreach (vecs[k]) begin
            do_reset();
            base_x = n_xfer;
            base_e = n_errp;
            for (int i = vecs[k].len - 1; i >= 0; i--) send(vecs[k].chars[8*i +: 8]);
            tick(3);
            check($sformatf("v%0d_xfers", k), 64'(n_xfer - base_x), 64'(vecs[k].exp_stb));
            check($sformatf("v%0d_errs", k), 64'(n_errp - base_e), 64'(vecs[k].exp_err));
            if (vecs[k].exp_stb != 0)
                check($sformatf("v%0d_word", k), 64'(last_word), 64'(vecs[k].exp_word));
            else
                check($sformatf("v%0d_no_stb", k), 64'(o_stb), 64'h0);
        end

        // Latency: o_stb rises on the edge that samples the command
        do_reset();
        send("1");
        check("lat_pre_stb", 64'(o_stb), 64'h0);
        send("W");
        check("lat_stb", 64'(o_stb), 64'h1);
        check("lat_word", 64'(o_word), 64'h0_0000_0001);
        tick(1);
        check("lat_stb_clear", 64'(o_stb), 64'h0);

        // Busy hold, dropped command, release, then reuse of retained digits
        do_reset();
        base_x = n_xfer;
        i_busy = 1'b1;
        send("5");
        send("A");
        check("busy_stb", 64'(o_stb), 64'h1);
        check("busy_word", 64'(o_word), 64'h2_0000_0005);
        send("7");
        send("W");
        check("busy_drop_err", 64'(o_err), 64'h1);
        check("busy_drop_word", 64'(o_word), 64'h2_0000_0005);
        tick(3);
        check("busy_hold_stb", 64'(o_stb), 64'h1);
        check("busy_hold_word", 64'(o_word), 64'h2_0000_0005);
        i_busy = 1'b0;
        tick(1);
        check("busy_release_stb", 64'(o_stb), 64'h0);
        check("busy_single_xfer", 64'(n_xfer - base_x), 64'h1);
        send("W");
        check("busy_after_stb", 64'(o_stb), 64'h1);
        check("busy_after_word", 64'(o_word), 64'h0_0000_0007);
        tick(2);
        check("busy_total_xfers", 64'(n_xfer - base_x), 64'h2);

        // Reset mid-sequence discards partial digits
        do_reset();
        send("1");
        send("2");
        i_reset = 1'b0;
        #2;
        check("midrst_stb", 64'(o_stb), 64'h0);
        check("midrst_err", 64'(o_err), 64'h0);
        tick(1);
        i_reset = 1'b1;
        base_x = n_xfer;
        tick(2);
        check("midrst_release_stb", 64'(o_stb), 64'h0);
        check("midrst_release_err", 64'(o_err), 64'h0);
        send("W");
        check("midrst_w_err", 64'(o_err), 64'h1);
        check("midrst_w_stb", 64'(o_stb), 64'h0);
        tick(2);
        check("midrst_no_xfer", 64'(n_xfer - base_x), 64'h0);

        // Transfer completing in the same cycle as a new 'R'
        do_reset();
        base_x = n_xfer;
        i_busy = 1'b1;
        send("R");
        send("3");
        check("b2b_first_word", 64'(o_word), 64'h1_0000_0000);
        i_busy = 1'b0;
        send("R");
        check("b2b_stb_still", 64'(o_stb), 64'h1);
        check("b2b_err", 64'(o_err), 64'h0);
        check("b2b_second_word", 64'(o_word), 64'h1_0000_0003);
        check("b2b_first_taken", 64'(last_word), 64'h1_0000_0000);
        tick(1);
        check("b2b_stb_clear", 64'(o_stb), 64'h0);
        check("b2b_xfers", 64'(n_xfer - base_x), 64'h2);
        check("b2b_last", 64'(last_word), 64'h1_0000_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
